// File: rtl/hyperbus_ca_latency_ctrl_if.sv
// Bus bundle for the HyperBus command-address / latency controller.
// The slave modport is the controller; the master modport is the host/PHY side.
interface hyperbus_ca_latency_ctrl_if #(
  parameter int LAT_W = 4
);
  logic             ca_valid_i;
  logic             ca_ready_o;
  logic [47:0]      cmd_addr_i;
  logic [LAT_W-1:0] cfg_latency_i;
  logic             rwds_i;
  logic [15:0]      tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic             cs_o;
  logic             data_phase_o;
  logic             data_done_i;

  modport slave (
    input  ca_valid_i,
    input  cmd_addr_i,
    input  cfg_latency_i,
    input  rwds_i,
    input  tx_ready_i,
    input  data_done_i,
    output ca_ready_o,
    output tx_data_o,
    output tx_valid_o,
    output cs_o,
    output data_phase_o
  );

  modport master (
    output ca_valid_i,
    output cmd_addr_i,
    output cfg_latency_i,
    output rwds_i,
    output tx_ready_i,
    output data_done_i,
    input  ca_ready_o,
    input  tx_data_o,
    input  tx_valid_o,
    input  cs_o,
    input  data_phase_o
  );
endinterface

// File: rtl/hyperbus_ca_latency_ctrl.sv
// HyperBus command-address sequencer with initial-latency timer and CS# high time.
// Optional RWDS-driven latency doubling is compiled in with HYPERBUS_ADDITIONAL_LAT_EN.
//
// state | meaning
// IDLE  | waiting for a command-address word, ca_ready_o=1
// CA    | sending the three 16-bit CA beats to the PHY
// LAT   | counting down the initial latency
// DATA  | data phase open until data_done_i
// END   | chip select deasserted for CSHI_CYCLES before the next command
module hyperbus_ca_latency_ctrl #(
  parameter int LAT_W       = 4,
  parameter int CSHI_CYCLES = 2
) (
  input logic                      clk_i,
  input logic                      rst_i,
  hyperbus_ca_latency_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA,
    S_LAT,
    S_DATA,
    S_END
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [47:0]      ca_q;
  logic [1:0]       beat_q;
  logic [LAT_W:0]   lat_cnt_q;
  logic [3:0]       end_cnt_q;

  logic             ca_hs;
  logic             beat_hs;
  logic             last_beat;
  logic             is_reg_wr;
  logic [LAT_W-1:0] lat_clamped;
  logic [LAT_W:0]   lat_n;
  logic [15:0]      beat_word;

  assign ca_hs     = bus.ca_valid_i && (state_q == S_IDLE) && !rst_i;
  assign beat_hs   = (state_q == S_CA) && bus.tx_ready_i;
  assign last_beat = beat_hs && (beat_q == 2'd2);
  assign is_reg_wr = ca_q[46] && !ca_q[47];

  // Latencies below 2 are not legal for the device, so treat them as 2.
  assign lat_clamped = (bus.cfg_latency_i < LAT_W'(2)) ? LAT_W'(2) : bus.cfg_latency_i;

`ifdef HYPERBUS_ADDITIONAL_LAT_EN
  logic add_lat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      add_lat_q <= 1'b0;
    end else if (beat_hs && (beat_q == 2'd0)) begin
      add_lat_q <= bus.rwds_i;
    end
  end

  assign lat_n = add_lat_q ? {lat_clamped, 1'b0} : {1'b0, lat_clamped};
`else
  logic unused_rwds;

  assign unused_rwds = bus.rwds_i;
  assign lat_n       = {1'b0, lat_clamped};
`endif

  always_comb begin
    beat_word = ca_q[15:0];
    case (beat_q)
      2'd0:    beat_word = ca_q[47:32];
      2'd1:    beat_word = ca_q[31:16];
      default: beat_word = ca_q[15:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ca_hs) state_d = S_CA;
      end
      S_CA: begin
        if (last_beat) state_d = is_reg_wr ? S_DATA : S_LAT;
      end
      S_LAT: begin
        if (lat_cnt_q <= (LAT_W+1)'(1)) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.data_done_i) state_d = S_END;
      end
      S_END: begin
        if (end_cnt_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state and forced to their idle values while reset is held.
  always_comb begin
    bus.ca_ready_o   = 1'b0;
    bus.tx_valid_o   = 1'b0;
    bus.tx_data_o    = 16'h0000;
    bus.cs_o         = 1'b0;
    bus.data_phase_o = 1'b0;
    if (!rst_i) begin
      bus.ca_ready_o   = (state_q == S_IDLE);
      bus.tx_valid_o   = (state_q == S_CA);
      bus.tx_data_o    = (state_q == S_CA) ? beat_word : 16'h0000;
      bus.cs_o         = (state_q == S_CA) || (state_q == S_LAT) || (state_q == S_DATA);
      bus.data_phase_o = (state_q == S_DATA);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ca_q      <= '0;
      beat_q    <= 2'd0;
      lat_cnt_q <= '0;
      end_cnt_q <= 4'd0;
    end else begin
      if (ca_hs) begin
        ca_q   <= bus.cmd_addr_i;
        beat_q <= 2'd0;
      end else if (beat_hs) begin
        beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
      end

      if (last_beat && !is_reg_wr) begin
        lat_cnt_q <= lat_n;
      end else if (state_q == S_LAT) begin
        lat_cnt_q <= lat_cnt_q - (LAT_W+1)'(1);
      end

      if ((state_q == S_DATA) && bus.data_done_i) begin
        end_cnt_q <= 4'(CSHI_CYCLES - 1);
      end else if ((state_q == S_END) && (end_cnt_q != 4'd0)) begin
        end_cnt_q <= end_cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_ca_latency_ctrl.sv
// Testbench for hyperbus_ca_latency_ctrl: per-cycle expected timelines built from transaction descriptions.
// Define HYPERBUS_ADDITIONAL_LAT_EN for both bench and RTL to exercise latency doubling.
module tb_hyperbus_ca_latency_ctrl;

  localparam int LAT_W = 4;
  localparam int CSHI  = 2;

  typedef struct {
    int          sid;
    logic        rst;
    logic        ca_valid;
    logic [47:0] cmd;
    logic [3:0]  cfg;
    logic        rwds;
    logic        tx_ready;
    logic        data_done;
    logic        e_ready;
    logic        e_valid;
    logic [15:0] e_data;
    logic        chk_data;
    logic        e_cs;
    logic        e_dp;
  } vec_t;

  typedef struct {
    logic [47:0] cmd;
    int          cfg;
    logic        rwds;
    int          s0;
    int          s1;
    int          s2;
    int          dlen;
    int          gap;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyperbus_ca_latency_ctrl_if #(.LAT_W(LAT_W)) bus ();

  hyperbus_ca_latency_ctrl #(.LAT_W(LAT_W), .CSHI_CYCLES(CSHI)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  function automatic vec_t base(input int sid);
    vec_t v;
    v.sid       = sid;
    v.rst       = 1'b0;
    v.ca_valid  = 1'($urandom_range(0, 1));
    v.cmd       = {16'($urandom), 32'($urandom)};
    v.cfg       = 4'($urandom_range(0, 15));
    v.rwds      = 1'($urandom_range(0, 1));
    v.tx_ready  = 1'($urandom_range(0, 1));
    v.data_done = 1'($urandom_range(0, 1));
    v.e_ready   = 1'b0;
    v.e_valid   = 1'b0;
    v.e_data    = 16'h0000;
    v.chk_data  = 1'b0;
    v.e_cs      = 1'b0;
    v.e_dp      = 1'b0;
    return v;
  endfunction

  // Expected cycle-by-cycle behaviour of one full transaction, starting from IDLE.
  task automatic build_txn(input int sid, input txn_t t);
    vec_t v;
    int   stall[3];
    int   n;
    stall[0] = t.s0; stall[1] = t.s1; stall[2] = t.s2;
    for (int g = 0; g < t.gap; g++) begin
      v = base(sid); v.ca_valid = 1'b0; v.e_ready = 1'b1; vq.push_back(v);
    end
    v = base(sid); v.ca_valid = 1'b1; v.cmd = t.cmd; v.e_ready = 1'b1; vq.push_back(v);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k <= stall[b]; k++) begin
        v = base(sid);
        v.tx_ready = (k == stall[b]);
        v.e_valid  = 1'b1;
        v.e_data   = t.cmd[47-16*b -: 16];
        v.chk_data = 1'b1;
        v.e_cs     = 1'b1;
        if (b == 0) v.rwds = (k == stall[b]) ? t.rwds : ~t.rwds;
        if (b == 2 && k == stall[b]) v.cfg = 4'(t.cfg);
        vq.push_back(v);
      end
    end
    if (!(t.cmd[46] && !t.cmd[47])) begin
      n = (t.cfg < 2) ? 2 : t.cfg;
`ifdef HYPERBUS_ADDITIONAL_LAT_EN
      if (t.rwds) n = 2 * n;
`endif
      for (int i = 0; i < n; i++) begin
        v = base(sid); v.e_cs = 1'b1; vq.push_back(v);
      end
    end
    for (int i = 0; i < t.dlen; i++) begin
      v = base(sid); v.data_done = (i == t.dlen - 1); v.e_cs = 1'b1; v.e_dp = 1'b1;
      vq.push_back(v);
    end
    for (int i = 0; i < CSHI; i++) begin
      v = base(sid); vq.push_back(v);
    end
  endtask

  task automatic push_reset(input int sid, input int cycles);
    vec_t v;
    for (int i = 0; i < cycles; i++) begin
      v = base(sid); v.rst = 1'b1; v.chk_data = 1'b1; vq.push_back(v);
    end
    v = base(sid); v.ca_valid = 1'b0; v.e_ready = 1'b1; vq.push_back(v);
  endtask

  task automatic apply_all();
    vec_t        v;
    logic [3:0]  got;
    logic [3:0]  exp;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk);
      #1;
      rst                = v.rst;
      bus.ca_valid_i     = v.ca_valid;
      bus.cmd_addr_i     = v.cmd;
      bus.cfg_latency_i  = v.cfg;
      bus.rwds_i         = v.rwds;
      bus.tx_ready_i     = v.tx_ready;
      bus.data_done_i    = v.data_done;
      @(negedge clk);
      got = {bus.ca_ready_o, bus.tx_valid_o, bus.cs_o, bus.data_phase_o};
      exp = {v.e_ready, v.e_valid, v.e_cs, v.e_dp};
      checks++;
      if (got !== exp || (v.chk_data && bus.tx_data_o !== v.e_data)) begin
        errors++;
        $display("FAIL scen%0d step%0d rdy/val/cs/dp got=%b exp=%b tx_data got=%h exp=%h (checked=%0b)",
                 v.sid, step, got, exp, bus.tx_data_o, v.e_data, v.chk_data);
      end
      step++;
    end
    vq.delete();
  endtask

  txn_t dir_tab[8];
  txn_t t;

  initial begin
    rst               = 1'b1;
    bus.ca_valid_i    = 1'b0;
    bus.cmd_addr_i    = '0;
    bus.cfg_latency_i = '0;
    bus.rwds_i        = 1'b0;
    bus.tx_ready_i    = 1'b0;
    bus.data_done_i   = 1'b0;

    dir_tab[0] = '{48'hA0C1_2345_0006,  6, 1'b0, 0, 0, 0, 2, 0};
    dir_tab[1] = '{48'hA0C1_2345_0006,  6, 1'b1, 0, 0, 0, 2, 0};
    dir_tab[2] = '{48'h6000_0000_0001,  6, 1'b0, 0, 0, 0, 1, 1};
    dir_tab[3] = '{48'hA0C1_2345_0006,  6, 1'b0, 0, 3, 0, 3, 0};
    dir_tab[4] = '{48'h2000_1111_2222,  0, 1'b0, 1, 0, 2, 1, 2};
    dir_tab[5] = '{48'hE000_3333_4444,  1, 1'b1, 0, 0, 0, 2, 0};
    dir_tab[6] = '{48'h8123_4567_89AB, 15, 1'b1, 2, 1, 0, 1, 0};
    dir_tab[7] = '{48'h4FFF_0000_FFFF,  2, 1'b1, 0, 0, 3, 4, 0};

    push_reset(0, 3);
    apply_all();

    for (int i = 0; i < 8; i++) build_txn(10 + i, dir_tab[i]);
    apply_all();

    // Reset while counting latency: handshake + 3 beats + 2 LAT cycles, then reset.
    build_txn(40, dir_tab[0]);
    while (vq.size() > 6) void'(vq.pop_back());
    push_reset(40, 1);
    build_txn(41, dir_tab[1]);
    apply_all();

    // Reset while beat 1 is stalled; next transaction must restart at beat 0.
    build_txn(42, dir_tab[3]);
    while (vq.size() > 4) void'(vq.pop_back());
    push_reset(42, 2);
    build_txn(43, dir_tab[0]);
    apply_all();

    for (int i = 0; i < 40; i++) begin
      t.cmd  = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) t.cmd[47:46] = 2'b01;
      t.cfg  = $urandom_range(0, 15);
      t.rwds = 1'($urandom_range(0, 1));
      t.s0   = $urandom_range(0, 3);
      t.s1   = $urandom_range(0, 3);
      t.s2   = $urandom_range(0, 3);
      t.dlen = $urandom_range(1, 4);
      t.gap  = $urandom_range(0, 2);
      build_txn(100 + i, t);
      apply_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
